// File: rtl/display_pkg.sv
// ============================================================================
//  Module      : display_pkg
//  Description : Framebuffer geometry, scheduler state encoding and the
//                page/column to byte-index helper shared by the OLED blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package display_pkg;

    localparam int FB_PAGES = 8;
    localparam int FB_COLS  = 128;
    localparam int FB_BYTES = FB_PAGES * FB_COLS;
    localparam int FB_BITS  = FB_BYTES * 8;

    // Scheduler states; ST_CLEAR is only reachable when the clear feature is built in.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACK   = 3'd1,
        ST_START = 3'd2,
        ST_SYNC  = 3'd3,
        ST_BUSY  = 3'd4,
        ST_CLEAR = 3'd5
    } sched_state_t;

    // Byte index inside the framebuffer: page*128 + col.
    function automatic logic [9:0] idx(input logic [2:0] page, input logic [6:0] col);
        return {page, col};
    endfunction

endpackage

`default_nettype wire

// File: rtl/arbitro_rr2.sv
// ============================================================================
//  Module      : arbitro_rr2
//  Description : Two-way round-robin arbiter. A lone request is granted
//                directly; on contention the pointer chooses. Whenever a
//                grant is consumed (advance) the pointer moves to the other
//                requester.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       pointer
);

    // One-hot grant: contention resolved by the pointer, single request passes through.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = pointer ? 2'b10 : 2'b01;
        end
    end

    // Pointer moves to the requester that was not just served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            pointer <= grant[0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/escalonador_display.sv
// ============================================================================
//  Module      : escalonador_display
//  Description : Owns the 8x128 byte OLED framebuffer, arbitrates byte writes
//                from two requesters, schedules full-frame refreshes towards
//                controlador_display and freezes writes while a frame is
//                being transmitted.
//  Options     : ESCALONADOR_CLEAR_EN - adds clear_req/clear_done and a
//                CLEAR state that zeroes the buffer one byte per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module escalonador_display
    import display_pkg::*;
#(
    parameter int MIN_FRAME_CYCLES = 50000,
    parameter int SYNC_TIMEOUT     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [5:0]         wr_page,
    input  logic [13:0]        wr_col,
    input  logic [15:0]        wr_data,
    output logic [1:0]         ack,
    output logic [FB_BITS-1:0] image,
    output logic               refresh_start,
    input  logic               display_busy,
    output logic               dirty
`ifdef ESCALONADOR_CLEAR_EN
    ,
    input  logic               clear_req,
    output logic               clear_done
`endif
);

    localparam int TIMER_W = (MIN_FRAME_CYCLES > 2) ? $clog2(MIN_FRAME_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(MIN_FRAME_CYCLES - 1);
    localparam int SYNC_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_TIMEOUT - 1);

    sched_state_t        state;
    sched_state_t        state_next;
    logic [TIMER_W-1:0]  timer;
    logic [SYNC_W-1:0]   sync_cnt;
    logic [1:0]          grant;
    logic                rr_pointer;
    logic                take_write;
    logic                take_start;
    logic                sync_expired;
    logic                timer_sat;
    logic                sel;
    logic [2:0]          sel_page;
    logic [6:0]          sel_col;
    logic [7:0]          sel_data;
    logic [12:0]         wr_base;
`ifdef ESCALONADOR_CLEAR_EN
    logic [9:0]          clr_cnt;
    logic                clr_last;
`endif

    assign timer_sat     = (timer == TIMER_MAX);
    assign refresh_start = (state == ST_START);
    assign take_write    = (state == ST_IDLE) && (state_next == ST_ACK);
    assign take_start    = (state == ST_IDLE) && (state_next == ST_START);
    assign sync_expired  = (state == ST_SYNC) && !display_busy && (sync_cnt == SYNC_LAST);

    // Address/data of whichever requester holds the grant this cycle.
    assign sel      = grant[1];
    assign sel_page = sel ? wr_page[5:3]  : wr_page[2:0];
    assign sel_col  = sel ? wr_col[13:7]  : wr_col[6:0];
    assign sel_data = sel ? wr_data[15:8] : wr_data[7:0];
    assign wr_base  = {idx(sel_page, sel_col), 3'b000};

`ifdef ESCALONADOR_CLEAR_EN
    assign clr_last = (clr_cnt == 10'd1023);
`endif

    arbitro_rr2 u_arbitro_rr2 (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (take_write),
        .grant   (grant),
        .pointer (rr_pointer)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a due refresh beats a clear, which beats a pending write.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (timer_sat && dirty && !display_busy) begin
                    state_next = ST_START;
`ifdef ESCALONADOR_CLEAR_EN
                end else if (clear_req) begin
                    state_next = ST_CLEAR;
`endif
                end else if (req != 2'b00) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK:   state_next = ST_IDLE;
            ST_START: state_next = ST_SYNC;
            ST_SYNC: begin
                if (display_busy) begin
                    state_next = ST_BUSY;
                end else if (sync_cnt == SYNC_LAST) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!display_busy) begin
                    state_next = ST_IDLE;
                end
            end
`ifdef ESCALONADOR_CLEAR_EN
            ST_CLEAR: begin
                if (clr_last) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default:  state_next = ST_IDLE;
        endcase
    end

    // Frame-period timer: saturates, restarts when a refresh is launched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (take_start) begin
            timer <= '0;
        end else if (!timer_sat) begin
            timer <= timer + 1'b1;
        end
    end

    // Counts cycles spent waiting for the display to acknowledge a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_cnt <= '0;
        end else if (state == ST_SYNC) begin
            sync_cnt <= sync_cnt + 1'b1;
        end else begin
            sync_cnt <= '0;
        end
    end

    // Acknowledge pulse lines up with the ACK state of the granted requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack <= 2'b00;
        end else begin
            ack <= take_write ? grant : 2'b00;
        end
    end

    // Dirty flag: any write sets it, a launched refresh clears it, a lost frame restores it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dirty <= 1'b0;
        end else if (take_start) begin
            dirty <= 1'b0;
        end else if (take_write || sync_expired) begin
            dirty <= 1'b1;
`ifdef ESCALONADOR_CLEAR_EN
        end else if ((state == ST_CLEAR) && clr_last) begin
            dirty <= 1'b1;
`endif
        end
    end

    // Framebuffer storage: one granted byte per write, or one zeroed byte per clear cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            image <= '0;
        end else if (take_write) begin
            image[wr_base +: 8] <= sel_data;
`ifdef ESCALONADOR_CLEAR_EN
        end else if (state == ST_CLEAR) begin
            image[{clr_cnt, 3'b000} +: 8] <= 8'h00;
`endif
        end
    end

`ifdef ESCALONADOR_CLEAR_EN
    // Clear sweep address and completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_cnt    <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= (state == ST_CLEAR) && clr_last;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end else begin
                clr_cnt <= '0;
            end
        end
    end
`endif

endmodule

`default_nettype wire
